// File: rtl/mdu_pkg.sv
// Shared op encodings and FSM state type for the multiply/divide unit.
// Pipeline decode imports the same encodings.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] den_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        ge      = (shifted >= {1'b0, den_i});
        diff    = shifted[WIDTH-1:0] - den_i;
        rem_o   = ge ? diff : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or one
// restoring-subtract step per cycle, followed by a sign-fix cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d, done_q, done_d, dbz_q, dbz_d;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, div_rem, div_quo, quo_fix, rem_fix;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .den_i (den_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        den_d     = den_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        signed_op = SIGNED_EN && ((op == OP_MULT) || (op == OP_DIV));
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag     = b_neg ? (~b + WIDTH'(1)) : b;

        // Shift-add multiply: rem holds the upper half, quo the shifting multiplier.
        mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, den_q} : '0);

        prod      = {rem_q, quo_q};
        prod_fix  = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
        quo_fix   = neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix   = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            rem_d    = '0;
                            quo_d    = b_mag;
                            den_d    = a_mag;
                            is_div_d = 1'b0;
                            neg_d    = a_neg ^ b_neg;
                            cnt_d    = '0;
                            state_d  = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            rem_d     = '0;
                            quo_d     = a_mag;
                            den_d     = b_mag;
                            is_div_d  = 1'b1;
                            neg_d     = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = (b == '0);
                            cnt_d     = '0;
                            state_d   = ST_RUN;
                        end
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = is_div_q ? div_rem : mul_sum[WIDTH:1];
                    quo_d = is_div_q ? div_quo : {mul_sum[0], quo_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Divide-by-zero still ran the full sequence; rem_fix equals a there.
                        hi_d  = rem_fix;
                        lo_d  = dz_q ? '1 : quo_fix;
                        dbz_d = dz_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            den_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            den_q     <= den_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32 with hand-computed results.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int lat;
    int bsy;
    int done_seen;

    mul_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request on the negedge; it is sampled at the next posedge (edge 0).
    task automatic launch(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after edge 0; returns the edge index of done and busy-high samples.
    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = busy ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                l = k;
                break;
            end
            if (busy) bc++;
        end
        if (l == 0) check("done_timeout", 64'(l), 64'd33);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // MULT -3 * 7 with latency and busy-length checks
        launch(3'b000, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bsy);
        check("mult_lat", 64'(lat), 64'd33);
        check("mult_busy_cycles", 64'(bsy), 64'd33);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        check("mult_busy_after", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);

        launch(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bsy);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);

        launch(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bsy);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        check("div_neg_dbz", 64'(div_by_zero), 64'd0);

        launch(3'b010, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, bsy);
        check("div_negb_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_negb_hi", 64'(hi), 64'd1);

        launch(3'b011, 32'd100, 32'd7);
        wait_done(lat, bsy);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);

        launch(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bsy);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'd0);
        check("div_ovf_dbz", 64'(div_by_zero), 64'd0);

        launch(3'b010, 32'd5, 32'd0);
        wait_done(lat, bsy);
        check("dbz_lat", 64'(lat), 64'd33);
        check("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dbz_hi", 64'(hi), 64'd5);
        check("dbz_flag", 64'(div_by_zero), 64'd1);

        // MTHI writes at the sampling edge; done is visible in the following cycle
        launch(3'b100, 32'h0000_1234, 32'd0);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd1);
        check("mthi_dbz_kept", 64'(div_by_zero), 64'd1);
        @(posedge clk);
        #1;
        check("mthi_done_drop", 64'(done), 64'd0);

        // MULTU 3x4 flushed at RUN cycle 10
        launch(3'b001, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_dbz_kept", 64'(div_by_zero), 64'd1);

        // flush and start together in IDLE: nothing starts
        @(negedge clk);
        op = 3'b001; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);

        // start during busy is ignored, not queued
        launch(3'b001, 32'd3, 32'd4);
        @(negedge clk);
        op = 3'b101; a = 32'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bsy);
        check("after_flush_lo", 64'(lo), 64'd12);
        check("after_flush_hi", 64'(hi), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_busy", 64'(busy), 64'd0);
        check("ignored_start_lo", 64'(lo), 64'd12);

        // Undefined op code
        launch(3'b110, 32'h77, 32'h77);
        check("undef_busy", 64'(busy), 64'd0);
        check("undef_done", 64'(done), 64'd0);

        // DIV 5/0 again so div_by_zero is set before the reset test
        launch(3'b010, 32'd5, 32'd0);
        wait_done(lat, bsy);
        check("dbz2_flag", 64'(div_by_zero), 64'd1);

        // Reset at RUN cycle 5 with the next request held through release
        launch(3'b000, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        op = 3'b001; a = 32'd6; b = 32'd7; start = 1'b1;
        #1;
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("rel_accept_busy", 64'(busy), 64'd1);
        wait_done(lat, bsy);
        check("rel_lat", 64'(lat), 64'd33);
        check("rel_lo", 64'(lo), 64'd42);
        check("rel_hi", 64'(hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
